uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for 8N1 frames, the counterpart of the team's UART transmitter. Samples the asynchronous serial line mid-bit and assembles LSB-first data bytes. Presents each byte with a one-cycle valid pulse and flags framing errors. Sits between the board RX pin and the data consumer (e.g. counter/control logic). Default rate is 9600 baud from a 25 MHz clock.

Parameters:
CLKS_PER_BIT, 2604, clock cycles per bit period (25 MHz / 9600); legal range ≥ 4.
HALF_BIT, CLKS_PER_BIT/2, sample offset into the start bit (integer division).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_data  input  1  asynchronous serial line; idle high
dout  output  8  last correctly received byte
rx_done  output  1  one-cycle pulse: dout updated with a new byte
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high whenever the state is not IDLE

Behaviour:
- All flops update on posedge clk. rst has priority over all other logic.
- Reset values: dout=8'h00, rx_done=0, frame_err=0, busy=0, state=IDLE, bit counter=0, clock counter=0, both synchronizer flops=1.
- Synchronizer: rx_data passes through 2 flops to give rx_s. All decisions use rx_s only.
- Clock counter width is clog2(CLKS_PER_BIT). It is cleared on every state change and on every bit sample.
- States and transitions:
  - IDLE: when rx_s==0, go to START and clear the counter.
  - START: count up. When counter==HALF_BIT-1, sample rx_s.
    - If 0: go to DATA and clear the counter.
    - If 1: the low pulse was a glitch; return to IDLE. No output pulse.
  - DATA: count 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift) and increment the bit counter.
    - The 8th sample (bit counter 7→0) goes to STOP. The first bit received ends up in shift[0] (LSB first).
  - STOP: at CLKS_PER_BIT-1, sample rx_s.
    - If 1: dout<=shift, rx_done=1 for 1 cycle, go to IDLE.
    - If 0: frame_err=1 for 1 cycle, dout unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break condition therefore never produces false starts.
- Latency: rx_done rises 2 cycles (synchronizer) + HALF_BIT + 9*CLKS_PER_BIT cycles after the rx_data start-bit falling edge, ±1 cycle. This is approximately mid stop bit.
- rx_done and frame_err are never high in the same cycle and never high for two consecutive cycles.
- dout holds its value until the next good frame.
- Back-to-back frames: after rx_done the block is in IDLE with about half a bit of stop time remaining. A start edge arriving right at the end of the stop bit must be caught.
- rx_s low on the very cycle IDLE is entered counts as a start.
- busy = (state != IDLE), registered with the state.
- Reset mid-frame: the next cycle is the reset state. No rx_done or frame_err pulse occurs, and dout returns to 8'h00.
- Unused/illegal state encodings go to IDLE.

Test Plan:
- Single frame (CLKS_PER_BIT=16 for sim): send 0xA5 8N1 → exactly one rx_done pulse, dout=8'hA5, frame_err never high, busy low after the pulse.
- Back-to-back: 0x00, 0xFF, 0x3C with a 1-bit stop and no idle gap → three rx_done pulses, dout sequence 00, FF, 3C, no frame_err.
- Glitch: rx_data low for 4 cycles (< HALF_BIT) then high → returns to IDLE, no rx_done/frame_err, dout unchanged.
- Framing error: send 0x55 with the stop bit held low for 3 bit times, then high, then a valid 0x12 → one frame_err pulse, dout still the prior value; then rx_done with dout=8'h12 and no spurious frame.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0xC3 → dout=00, busy=0, no pulses. A following 0x81 frame is received correctly.
- Default parameter smoke test at 2604: one 0x5A frame at 9600 baud → rx_done within ±1 cycle of the computed latency, dout=8'h5A.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchronizer, mid-bit sampling and framing-error detection
module uart_rx #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic [7:0] dout,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_rx_s;
    logic          w_last;
    logic          w_half;
    logic          w_sample;
    logic          w_stop_chk;

    assign w_rx_s     = r_sync2;
    assign w_last     = r_cnt == CNT_LAST;
    assign w_half     = r_cnt == CNT_HALF;
    assign w_sample   = r_state == DATA && w_last;
    assign w_stop_chk = r_state == STOP && w_last;

    // bring the asynchronous line into the clock domain; idle-high on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_data;
            r_sync2 <= r_sync1;
        end
    end

    // next-state decision; a high start-bit sample is a glitch, a low stop bit waits for the line to recover
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_rx_s ? IDLE : START;
            START:     w_next = w_half ? (w_rx_s ? IDLE : DATA) : START;
            DATA:      w_next = (w_last && r_bit == 3'd7) ? STOP : DATA;
            STOP:      w_next = w_last ? (w_rx_s ? IDLE : WAIT_HIGH) : STOP;
            WAIT_HIGH: w_next = w_rx_s ? IDLE : WAIT_HIGH;
            default:   w_next = IDLE;
        endcase
    end

    // state register, bit-period counter and busy flag registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || w_sample || r_state == IDLE || r_state == WAIT_HIGH) ? '0 : r_cnt + 1'b1;
            busy    <= w_next != IDLE;
        end
    end

    // shift data bits in LSB first; the bit counter wraps 7->0 on the last data bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= 8'h00;
            r_bit   <= 3'd0;
        end else if (w_sample) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
        end
    end

    // stop-bit verdict: publish the byte on a good stop bit, flag a framing error otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= w_stop_chk && w_rx_s;
            frame_err <= w_stop_chk && !w_rx_s;
            if (w_stop_chk && w_rx_s)
                dout <= r_shift;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard-driven bench for uart_rx at a short bit period plus a default-rate smoke test
module tb_uart_rx;
    localparam int CPB   = 16;
    localparam int CPB2  = 2604;
    localparam int HALF2 = CPB2 / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx1 = 1'b1;
    logic       rx2 = 1'b1;
    logic [7:0] dout1, dout2;
    logic       done1, done2, ferr1, ferr2, busy1, busy2;

    int         checks    = 0;
    int         errors    = 0;
    int         n_done    = 0;
    int         n_ferr    = 0;
    int         n_done2   = 0;
    int         cyc       = 0;
    int         done_cyc2 = 0;
    bit         prev_pulse = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx_data(rx1),
        .dout(dout1), .rx_done(done1), .frame_err(ferr1), .busy(busy1)
    );

    uart_rx dut2 (
        .clk(clk), .rst(rst), .rx_data(rx2),
        .dout(dout2), .rx_done(done2), .frame_err(ferr2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pop the scoreboard on every rx_done and check pulse shape
    always @(negedge clk) begin
        if (done1) begin
            n_done++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_done_unexpected: dout=%02h with no expected byte", dout1);
            end else begin
                exp_b = exp_q.pop_front();
                if (dout1 !== exp_b) begin
                    errors++;
                    $display("FAIL scoreboard_dout: got %02h expected %02h", dout1, exp_b);
                end
            end
        end
        if (ferr1) n_ferr++;
        if (done1 || ferr1) begin
            checks++;
            if ((done1 && ferr1) || prev_pulse) begin
                errors++;
                $display("FAIL pulse_shape: rx_done=%b frame_err=%b prev_pulse=%b expected single isolated pulse", done1, ferr1, prev_pulse);
            end
        end
        prev_pulse = done1 | ferr1;
        if (done2) begin
            n_done2++;
            done_cyc2 = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input bit sel, input bit v, input int n);
        if (sel) rx2 = v;
        else rx1 = v;
        idle(n);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input int cpb);
        bit_out(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) bit_out(sel, b[i], cpb);
        bit_out(sel, 1'b1, cpb);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if ({dout1, done1, ferr1, busy1} !== 11'h000) begin
            errors++;
            $display("FAIL reset_dut1: got dout=%02h done=%b ferr=%b busy=%b expected all zero", dout1, done1, ferr1, busy1);
        end
        checks++;
        if ({dout2, done2, ferr2, busy2} !== 11'h000) begin
            errors++;
            $display("FAIL reset_dut2: got dout=%02h done=%b ferr=%b busy=%b expected all zero", dout2, done2, ferr2, busy2);
        end
        rst = 1'b0;
        idle(4);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy got %b expected 0", busy1);
        end
    endtask

    task automatic test_single();
        int d0 = n_done;
        int f0 = n_ferr;
        exp_q.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, CPB);
        idle(2 * CPB);
        checks++;
        if (n_done !== d0 + 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d expected %0d", n_done - d0, 1);
        end
        checks++;
        if (n_ferr !== f0) begin
            errors++;
            $display("FAIL single_no_ferr: got %0d expected 0", n_ferr - f0);
        end
        checks++;
        if (dout1 !== 8'hA5 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL single_final: got dout=%02h busy=%b expected dout=a5 busy=0", dout1, busy1);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = n_done;
        int f0 = n_ferr;
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
        for (int i = 0; i < 3; i++) send_frame(1'b0, bytes[i], CPB);
        idle(2 * CPB);
        checks++;
        if (n_done !== d0 + 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d pending=%0d expected 3 pending=0", n_done - d0, exp_q.size());
        end
        checks++;
        if (n_ferr !== f0 || dout1 !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_final: got ferr=%0d dout=%02h expected ferr=0 dout=3c", n_ferr - f0, dout1);
        end
    endtask

    task automatic test_glitch();
        int d0 = n_done;
        int f0 = n_ferr;
        rx1 = 1'b0;
        idle(4);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start_seen: busy got %b expected 1", busy1);
        end
        rx1 = 1'b1;
        idle(2 * CPB);
        checks++;
        if (n_done !== d0 || n_ferr !== f0 || dout1 !== 8'h3C || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: got done=%0d ferr=%0d dout=%02h busy=%b expected 0 0 3c 0", n_done - d0, n_ferr - f0, dout1, busy1);
        end
    endtask

    task automatic test_frame_err();
        int d0 = n_done;
        int f0 = n_ferr;
        logic [7:0] b = 8'h55;
        bit_out(1'b0, 1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_out(1'b0, b[i], CPB);
        bit_out(1'b0, 1'b0, 3 * CPB);
        checks++;
        if (n_ferr !== f0 + 1 || n_done !== d0 || dout1 !== 8'h3C || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL ferr_detect: got ferr=%0d done=%0d dout=%02h busy=%b expected 1 0 3c 1", n_ferr - f0, n_done - d0, dout1, busy1);
        end
        bit_out(1'b0, 1'b1, CPB);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL ferr_recover: busy got %b expected 0", busy1);
        end
        exp_q.push_back(8'h12);
        send_frame(1'b0, 8'h12, CPB);
        idle(2 * CPB);
        checks++;
        if (n_done !== d0 + 1 || n_ferr !== f0 + 1 || dout1 !== 8'h12) begin
            errors++;
            $display("FAIL ferr_next_frame: got done=%0d ferr=%0d dout=%02h expected 1 1 12", n_done - d0, n_ferr - f0, dout1);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = n_done;
        int f0 = n_ferr;
        logic [7:0] b = 8'hC3;
        bit_out(1'b0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) bit_out(1'b0, b[i], CPB);
        bit_out(1'b0, b[4], CPB / 2);
        rst = 1'b1;
        idle(1);
        checks++;
        if (dout1 !== 8'h00 || busy1 !== 1'b0 || done1 !== 1'b0 || ferr1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: got dout=%02h busy=%b done=%b ferr=%b expected 00 0 0 0", dout1, busy1, done1, ferr1);
        end
        rst = 1'b0;
        rx1 = 1'b1;
        idle(3 * CPB);
        checks++;
        if (n_done !== d0 || n_ferr !== f0 || dout1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_quiet: got done=%0d ferr=%0d dout=%02h expected 0 0 00", n_done - d0, n_ferr - f0, dout1);
        end
        exp_q.push_back(8'h81);
        send_frame(1'b0, 8'h81, CPB);
        idle(2 * CPB);
        checks++;
        if (n_done !== d0 + 1 || dout1 !== 8'h81) begin
            errors++;
            $display("FAIL reset_mid_next: got done=%0d dout=%02h expected 1 81", n_done - d0, dout1);
        end
    endtask

    task automatic test_default_rate();
        int edge_cyc = cyc + 1;
        int lat;
        int exp_lat = 2 + HALF2 + 9 * CPB2;
        send_frame(1'b1, 8'h5A, CPB2);
        idle(CPB2);
        lat = done_cyc2 - edge_cyc;
        checks++;
        if (n_done2 !== 1 || dout2 !== 8'h5A) begin
            errors++;
            $display("FAIL default_frame: got done=%0d dout=%02h expected 1 5a", n_done2, dout2);
        end
        checks++;
        if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            errors++;
            $display("FAIL default_latency: got %0d expected %0d +/-1", lat, exp_lat);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_default_rate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
